wb_uart: RTL and testbench

Wishbone-slave UART that fills the uart0/uart1 slots on the 16-bit conbus, serving the SPI bus master. It provides a transmit FIFO, a receive FIFO, 8N1 framing, a programmable 16x-oversampling baud generator and a level interrupt. It sits directly downstream of the interconnect slave port and drives an external TX/RX pin pair.

---
 rtl/wb_uart_pkg.sv | 35 +++
 rtl/uart_fifo.sv | 51 +++++
 rtl/wb_uart.sv | 236 +++++++++++++++++++++++
 tb/tb_wb_uart.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_uart_pkg.sv
// Shared definitions for the wb_uart slice: register map, STATUS/CTRL bit positions,
// serial FSM state encoding and oversampling constants.
package wb_uart_pkg;

    localparam logic [1:0] ADR_DATA   = 2'd0;
    localparam logic [1:0] ADR_STATUS = 2'd1;
    localparam logic [1:0] ADR_DIV    = 2'd2;
    localparam logic [1:0] ADR_CTRL   = 2'd3;

    localparam int ST_RX_AVAIL = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_TX_EMPTY = 2;
    localparam int ST_TX_IDLE  = 3;
    localparam int ST_RX_OVR   = 4;
    localparam int ST_FRM_ERR  = 5;
    localparam int ST_TX_OVF   = 6;

    localparam int CT_IE_RX  = 0;
    localparam int CT_IE_TX  = 1;
    localparam int CT_IE_ERR = 2;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;

    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] MID_TICK  = 4'(MID_SAMPLE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/uart_fifo.sv
// 8-bit synchronous FIFO, show-ahead dout, 2**AW entries; pop when empty is ignored,
// push when full is dropped unless a pop frees a slot in the same cycle.
module uart_fifo #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam int DEPTH = 1 << AW;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign empty     = (r_count == '0);
    // count never exceeds DEPTH, so its MSB alone marks full
    assign full      = r_count[AW];
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/wb_uart.sv
// Wishbone-slave 8N1 UART: TX/RX FIFOs, 16x baud generator, level irq; read data one cycle after access.
// No ack or stall: a push to a full TX FIFO or an RX byte into a full RX FIFO is dropped and flagged.
module wb_uart
    import wb_uart_pkg::*;
#(
    parameter int          FIFO_AW     = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd108
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    input  logic [13:0] wb_adr_i,
    input  logic [1:0]  wb_sel_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);

    logic              r_req_q, w_acc, w_wr, w_rd;
    logic [1:0]        w_adr;
    logic [15:0]       r_div, r_baud_cnt, r_dat_o, w_status, w_rd_dat;
    logic [2:0]        r_ctrl, w_irq_src;
    logic              w_tick, r_irq;
    logic              r_rx_ovr, r_frm_err, r_tx_ovf;

    logic              w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
    logic [7:0]        w_tx_dout;
    logic [FIFO_AW:0]  w_tx_count;
    logic              w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
    logic [7:0]        w_rx_dout;
    logic [FIFO_AW:0]  w_rx_count;

    uart_state_t       r_tx_state, r_rx_state;
    logic [3:0]        r_tx_cnt, r_rx_cnt;
    logic [2:0]        r_tx_bit, r_rx_bit;
    logic [7:0]        r_tx_shift, r_rx_shift;
    logic              r_tx, r_rx_s1, r_rx_s2;
    logic              w_rx_stop, w_unused;

    assign w_unused = ^{wb_adr_i[13:2], wb_sel_i, w_tx_count};

    // A held strobe counts once: only its first cycle is an access
    assign w_acc = wb_stb_i & wb_cyc_i & ~r_req_q;
    assign w_wr  = w_acc & wb_we_i;
    assign w_rd  = w_acc & ~wb_we_i;
    assign w_adr = wb_adr_i[1:0];

    assign w_tick    = (r_baud_cnt == r_div);
    assign w_tx_push = w_wr && (w_adr == ADR_DATA);
    assign w_rx_pop  = w_rd && (w_adr == ADR_DATA) && !w_rx_empty;
    assign w_tx_pop  = w_tick && !w_tx_empty &&
                       ((r_tx_state == S_IDLE) ||
                        ((r_tx_state == S_STOP) && (r_tx_cnt == LAST_TICK)));
    assign w_rx_stop = w_tick && (r_rx_state == S_STOP) && (r_rx_cnt == LAST_TICK);
    assign w_rx_push = w_rx_stop && r_rx_s2;

    uart_fifo #(.AW(FIFO_AW)) u_tx_fifo (
        .clk(clk), .rst_n(resetn), .push(w_tx_push), .pop(w_tx_pop), .din(wb_dat_i[7:0]),
        .dout(w_tx_dout), .full(w_tx_full), .empty(w_tx_empty), .count(w_tx_count)
    );

    uart_fifo #(.AW(FIFO_AW)) u_rx_fifo (
        .clk(clk), .rst_n(resetn), .push(w_rx_push), .pop(w_rx_pop), .din(r_rx_shift),
        .dout(w_rx_dout), .full(w_rx_full), .empty(w_rx_empty), .count(w_rx_count)
    );

    always_comb begin
        w_status              = '0;
        w_status[ST_RX_AVAIL] = ~w_rx_empty;
        w_status[ST_TX_FULL]  = w_tx_full;
        w_status[ST_TX_EMPTY] = w_tx_empty;
        w_status[ST_TX_IDLE]  = w_tx_empty && (r_tx_state == S_IDLE);
        w_status[ST_RX_OVR]   = r_rx_ovr;
        w_status[ST_FRM_ERR]  = r_frm_err;
        w_status[ST_TX_OVF]   = r_tx_ovf;
        w_status[15:8]        = 8'(w_rx_count);
    end

    always_comb begin
        w_rd_dat = '0;
        case (w_adr)
            ADR_DATA:   w_rd_dat = w_rx_empty ? 16'h0 : {8'h0, w_rx_dout};
            ADR_STATUS: w_rd_dat = w_status;
            ADR_DIV:    w_rd_dat = r_div;
            default:    w_rd_dat = {13'h0, r_ctrl};
        endcase
    end

    assign w_irq_src = {r_rx_ovr | r_frm_err | r_tx_ovf, w_tx_empty, ~w_rx_empty};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_req_q    <= 1'b0;
            r_dat_o    <= '0;
            r_div      <= DEFAULT_DIV;
            r_baud_cnt <= '0;
            r_ctrl     <= '0;
            r_irq      <= 1'b0;
            r_rx_ovr   <= 1'b0;
            r_frm_err  <= 1'b0;
            r_tx_ovf   <= 1'b0;
        end else begin
            r_req_q <= wb_stb_i & wb_cyc_i;
            if (w_rd) r_dat_o <= w_rd_dat;
            if (w_wr && (w_adr == ADR_DIV)) begin
                r_div      <= wb_dat_i;
                r_baud_cnt <= '0;
            end else if (w_tick) begin
                r_baud_cnt <= '0;
            end else begin
                r_baud_cnt <= r_baud_cnt + 16'd1;
            end
            if (w_wr && (w_adr == ADR_CTRL)) r_ctrl <= wb_dat_i[2:0];
            // Clears first so a same-cycle event still leaves its flag set
            if (w_wr && (w_adr == ADR_STATUS)) begin
                if (wb_dat_i[ST_RX_OVR])  r_rx_ovr  <= 1'b0;
                if (wb_dat_i[ST_FRM_ERR]) r_frm_err <= 1'b0;
                if (wb_dat_i[ST_TX_OVF])  r_tx_ovf  <= 1'b0;
            end
            if (w_rx_push && w_rx_full && !w_rx_pop) r_rx_ovr  <= 1'b1;
            if (w_rx_stop && !r_rx_s2)               r_frm_err <= 1'b1;
            if (w_tx_push && w_tx_full && !w_tx_pop) r_tx_ovf  <= 1'b1;
            r_irq <= |(r_ctrl & w_irq_src);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tx_state <= S_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx       <= 1'b1;
        end else if (w_tick) begin
            case (r_tx_state)
                S_IDLE: if (w_tx_pop) begin
                    r_tx_state <= S_START;
                    r_tx_cnt   <= '0;
                    r_tx_shift <= w_tx_dout;
                    r_tx       <= 1'b0;
                end
                S_START: if (r_tx_cnt == LAST_TICK) begin
                    r_tx_state <= S_DATA;
                    r_tx_cnt   <= '0;
                    r_tx_bit   <= '0;
                    r_tx       <= r_tx_shift[0];
                end else begin
                    r_tx_cnt <= r_tx_cnt + 4'd1;
                end
                S_DATA: if (r_tx_cnt == LAST_TICK) begin
                    r_tx_cnt <= '0;
                    if (r_tx_bit == 3'd7) begin
                        r_tx_state <= S_STOP;
                        r_tx       <= 1'b1;
                    end else begin
                        r_tx_bit   <= r_tx_bit + 3'd1;
                        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        r_tx       <= r_tx_shift[1];
                    end
                end else begin
                    r_tx_cnt <= r_tx_cnt + 4'd1;
                end
                S_STOP: if (r_tx_cnt == LAST_TICK) begin
                    r_tx_cnt <= '0;
                    if (w_tx_pop) begin
                        r_tx_state <= S_START;
                        r_tx_shift <= w_tx_dout;
                        r_tx       <= 1'b0;
                    end else begin
                        r_tx_state <= S_IDLE;
                    end
                end else begin
                    r_tx_cnt <= r_tx_cnt + 4'd1;
                end
                default: r_tx_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_state <= S_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_s1 <= uart_rx;
            r_rx_s2 <= r_rx_s1;
            case (r_rx_state)
                S_IDLE: if (!r_rx_s2) begin
                    r_rx_state <= S_START;
                    r_rx_cnt   <= '0;
                end
                S_START: if (w_tick) begin
                    if (r_rx_cnt == MID_TICK) begin
                        r_rx_cnt   <= '0;
                        r_rx_bit   <= '0;
                        r_rx_state <= r_rx_s2 ? S_IDLE : S_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 4'd1;
                    end
                end
                S_DATA: if (w_tick) begin
                    if (r_rx_cnt == LAST_TICK) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                        if (r_rx_bit == 3'd7) r_rx_state <= S_STOP;
                        else                  r_rx_bit   <= r_rx_bit + 3'd1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 4'd1;
                    end
                end
                S_STOP: if (w_tick) begin
                    if (r_rx_cnt == LAST_TICK) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= S_IDLE;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 4'd1;
                    end
                end
                default: r_rx_state <= S_IDLE;
            endcase
        end
    end

    assign uart_tx  = r_tx;
    assign irq      = r_irq;
    assign wb_dat_o = r_dat_o;

endmodule

// File: tb/tb_wb_uart.sv
// Randomized self-checking bench for wb_uart: bus accesses, serial frames driven/captured
// at bit level, and a queue-based model of the RX FIFO and sticky flags.
`timescale 1ns/1ps
module tb_wb_uart;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        wb_stb_i = 1'b0, wb_cyc_i = 1'b0, wb_we_i = 1'b0;
    logic [13:0] wb_adr_i = '0;
    logic [1:0]  wb_sel_i = 2'b11;
    logic [15:0] wb_dat_i = '0;
    logic [15:0] wb_dat_o;
    logic        uart_tx, irq, uart_rx;
    logic        rx_drv = 1'b1, loopback = 1'b0;

    int total = 0, bad = 0;
    byte unsigned rxq[$];
    byte unsigned txq[$];
    logic m_ovr = 1'b0;

    assign uart_rx = loopback ? uart_tx : rx_drv;

    always #5 clk = ~clk;

    wb_uart dut (
        .clk(clk), .resetn(resetn), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
        .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o), .uart_rx(uart_rx), .uart_tx(uart_tx), .irq(irq)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wb_write(input logic [1:0] a, input logic [15:0] d);
        @(negedge clk);
        wb_adr_i = {12'h0, a}; wb_dat_i = d; wb_we_i = 1'b1;
        wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
        @(negedge clk);
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic wb_read(input logic [1:0] a, input int hold, output logic [15:0] d);
        @(negedge clk);
        wb_adr_i = {12'h0, a}; wb_we_i = 1'b0;
        wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
        repeat (hold) @(negedge clk);
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
        d = wb_dat_o;
    endtask

    // Stop bit of 0 is held only 3/4 of a bit so the line is idle again by the next sample point
    task automatic send_frame(input byte unsigned b, input logic stop, input int bp);
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (bp) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (bp) @(negedge clk);
        end
        rx_drv = stop;
        repeat (stop ? bp : (bp * 3) / 4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (bp) @(negedge clk);
    endtask

    task automatic model_rx(input byte unsigned b);
        if (rxq.size() < 16) rxq.push_back(b);
        else m_ovr = 1'b1;
    endtask

    task automatic capture_tx(input int bp, output logic [7:0] b, output logic ok);
        int n;
        n = 0; ok = 1'b0; b = '0;
        while (uart_tx !== 1'b0 && n < 40 * bp) begin
            @(negedge clk);
            n++;
        end
        if (uart_tx !== 1'b0) return;
        repeat (bp / 2) @(negedge clk);
        if (uart_tx !== 1'b0) return;
        for (int i = 0; i < 8; i++) begin
            repeat (bp) @(negedge clk);
            b[i] = uart_tx;
        end
        repeat (bp) @(negedge clk);
        ok = uart_tx;
    endtask

    initial begin
        #900us;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [15:0] d;
        logic [7:0]  b55;
        int          n;
        logic        exp_bit;

        repeat (3) @(negedge clk);
        resetn = 1'b1;

        // Reset state
        chk("rst_tx", uart_tx, 1);
        chk("rst_irq", irq, 0);
        chk("rst_dat_o", wb_dat_o, 0);
        wb_read(1, 1, d); chk("rst_status", d, 16'h000C);
        wb_read(2, 1, d); chk("rst_div", d, 108);
        wb_read(3, 1, d); chk("rst_ctrl", d, 0);

        // Exact 0x55 waveform at DIV=0
        b55 = 8'h55;
        wb_write(2, 16'h0);
        wb_write(0, 16'h0055);
        n = 0;
        while (uart_tx !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        chk("t55_start_seen", uart_tx, 0);
        for (int i = 0; i < 160; i++) begin
            if (i < 16)        exp_bit = 1'b0;
            else if (i >= 144) exp_bit = 1'b1;
            else               exp_bit = b55[(i / 16) - 1];
            if ((i % 16) == 0 || (i % 16) == 15) chk("t55_bit", uart_tx, exp_bit);
            @(negedge clk);
        end
        wb_read(1, 1, d); chk("t55_idle_empty", d[3:2], 2'b11);

        // Loopback, strobe held over several cycles pops once
        loopback = 1'b1;
        wb_write(0, 16'h00A5);
        wb_write(0, 16'h003C);
        n = 0;
        do begin wb_read(1, 1, d); n++; end while (d[15:8] != 8'd2 && n < 500);
        chk("lb_count2", d[15:8], 2);
        wb_read(0, 3, d); chk("lb_first", d, 16'h00A5);
        wb_read(1, 1, d); chk("lb_count1", d[15:8], 1);
        wb_read(0, 1, d); chk("lb_second", d, 16'h003C);
        wb_read(1, 1, d); chk("lb_avail0", d[0], 0);
        wb_read(0, 1, d); chk("lb_empty_read", d, 0);
        loopback = 1'b0;

        // Random TX/RX traffic over several divisors
        for (int it = 0; it < 4; it++) begin
            int dv, bp, nb;
            dv = $urandom_range(0, 2);
            bp = 16 * (dv + 1);
            nb = $urandom_range(1, 3);
            wb_write(2, 16'(dv));
            wb_read(2, 1, d); chk("rnd_div", d, dv);
            fork
                for (int j = 0; j < nb; j++) begin
                    byte unsigned v;
                    v = 8'($urandom);
                    txq.push_back(v);
                    wb_write(0, {8'h0, v});
                end
                for (int j = 0; j < nb; j++) begin
                    logic [7:0] cb;
                    logic       ok;
                    capture_tx(bp, cb, ok);
                    chk("rnd_tx_frame", ok, 1);
                    chk("rnd_tx_byte", cb, txq.pop_front());
                end
            join
            nb = $urandom_range(1, 3);
            for (int j = 0; j < nb; j++) begin
                byte unsigned v;
                v = 8'($urandom);
                send_frame(v, 1'b1, bp);
                model_rx(v);
            end
            wb_read(1, 1, d); chk("rnd_rx_count", d[15:8], rxq.size());
            while (rxq.size() > 0) begin
                wb_read(0, 1, d); chk("rnd_rx_byte", d, {8'h0, rxq.pop_front()});
            end
        end

        // TX overflow with the shifter stalled
        wb_write(2, 16'hFFFF);
        for (int i = 0; i < 17; i++) wb_write(0, 16'(i));
        wb_read(1, 1, d);
        chk("ovf_full", d[1], 1);
        chk("ovf_flag", d[6], 1);
        chk("ovf_not_empty", d[2], 0);
        wb_write(1, 16'h0040);
        wb_read(1, 1, d);
        chk("ovf_cleared", d[6], 0);
        chk("ovf_still_full", d[1], 1);
        @(negedge clk); resetn = 1'b0;
        repeat (3) @(negedge clk); resetn = 1'b1;

        // RX overrun: 17 frames, nothing read
        wb_write(2, 16'h0);
        m_ovr = 1'b0;
        for (int j = 0; j < 17; j++) begin
            byte unsigned v;
            v = 8'($urandom);
            send_frame(v, 1'b1, 16);
            model_rx(v);
        end
        wb_read(1, 1, d);
        chk("ovr_count", d[15:8], rxq.size());
        chk("ovr_flag", d[4], m_ovr);
        wb_read(0, 1, d); chk("ovr_first_byte", d, {8'h0, rxq.pop_front()});
        while (rxq.size() > 0) begin
            wb_read(0, 1, d); chk("ovr_byte", d, {8'h0, rxq.pop_front()});
        end
        wb_write(1, 16'h0010);
        wb_read(1, 1, d); chk("ovr_cleared", d[4], 0);

        // Framing error, then a short glitch
        send_frame(8'h5A, 1'b0, 16);
        wb_read(1, 1, d);
        chk("ferr_flag", d[5], 1);
        chk("ferr_no_push", d[15:8], 0);
        wb_write(1, 16'h0020);
        @(negedge clk); rx_drv = 1'b0;
        repeat (4) @(negedge clk); rx_drv = 1'b1;
        repeat (100) @(negedge clk);
        wb_read(1, 1, d);
        chk("glitch_status", d, 16'h000C);
        send_frame(8'hC3, 1'b1, 16);
        wb_read(0, 1, d); chk("post_glitch_byte", d, 16'h00C3);

        // Interrupts
        wb_write(3, 16'h0001);
        wb_read(3, 1, d); chk("ctrl_rb", d, 1);
        chk("irq_idle", irq, 0);
        send_frame(8'h7E, 1'b1, 16);
        chk("irq_rx", irq, 1);
        wb_read(0, 1, d);
        chk("irq_byte", d, 16'h007E);
        chk("irq_held", irq, 1);
        @(negedge clk);
        chk("irq_drop", irq, 0);
        wb_write(3, 16'h0002);
        repeat (2) @(negedge clk);
        chk("irq_txempty", irq, 1);
        wb_write(3, 16'h0004);
        repeat (2) @(negedge clk);
        chk("irq_err_none", irq, 0);
        wb_write(3, 16'h0000);

        // Reset mid-frame
        send_frame(8'h11, 1'b1, 16);
        wb_write(0, 16'h0000);
        wb_write(0, 16'h00FF);
        repeat (40) @(negedge clk);
        chk("mid_frame_low", uart_tx, 0);
        resetn = 1'b0;
        #1;
        chk("rst_async_tx", uart_tx, 1);
        chk("rst_async_irq", irq, 0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        wb_read(1, 1, d); chk("rst_fifos_empty", d, 16'h000C);
        repeat (50) @(negedge clk);
        chk("rst_tx_quiet", uart_tx, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
